// File: rtl/ones_comp_pkg.sv
// Shared types and elaboration helpers for the serial ones'-complement ALU.
// State codes stay plain 2-bit constants so older blocks can compare them directly.
package ones_comp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ADD  = 2'd1;
  localparam state_t WRAP = 2'd2;
  localparam state_t DONE = 2'd3;

  // Digit cycles per pass.
  function automatic int unsigned num_digits(input int unsigned width,
                                             input int unsigned digit);
    return width / digit;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned digit);
    return (digit != 0) && (width != 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/ones_comp_serial_alu_if.sv
// Operand/result handshake bundle between the switch front-end and the ALU.
// master drives operands and accepts results; slave is the ALU side.
interface ones_comp_serial_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             neg_zero;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, ovf, neg_zero, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, ovf, neg_zero, busy
  );

endinterface

// File: rtl/oc_digit_adder.sv
// DIGIT-bit ripple adder built from full adder cells; shared across all digits
// of an operation by the serial ALU.
module oc_digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    oc_full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/oc_full_adder.sv
// Single-bit full adder cell.
module oc_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/ones_comp_serial_alu.sv
// Digit-serial ones'-complement add/subtract: one ADD pass over all digits, then an
// optional WRAP pass that folds the end-around carry back in.
module ones_comp_serial_alu
  import ones_comp_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DIGIT          = 4,
  parameter int unsigned NORMALIZE_ZERO = 0
) (
  input logic                   clk,
  input logic                   reset,
  ones_comp_serial_alu_if.slave bus
);

  localparam int unsigned N     = num_digits(WIDTH, DIGIT);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("ones_comp_serial_alu: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             neg_zero_q, neg_zero_d;

  logic [DIGIT-1:0] dig_x, dig_y, dig_s;
  logic             dig_co;
  logic             finish;

  // WRAP re-adds the partial sum with a zero operand; the end-around 1 enters as cin.
  always_comb begin
    dig_x = '0;
    dig_y = '0;
    if (state_q == WRAP) begin
      dig_x = sum_q[idx_q*DIGIT +: DIGIT];
    end else begin
      dig_x = a_q[idx_q*DIGIT +: DIGIT];
      dig_y = b_q[idx_q*DIGIT +: DIGIT];
    end
  end

  oc_digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .x    (dig_x),
    .y    (dig_y),
    .cin  (carry_q),
    .sum  (dig_s),
    .cout (dig_co)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    neg_zero_d = neg_zero_q;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          sum_d   = '0;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q*DIGIT +: DIGIT] = dig_s;
        carry_d = dig_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d = '0;
          if (dig_co) begin
            carry_d = 1'b1;
            state_d = WRAP;
          end else begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WRAP: begin
        sum_d[idx_q*DIGIT +: DIGIT] = dig_s;
        carry_d = dig_co;
        idx_d   = idx_q + 1'b1;
        // Fixed-length pass; the final carry out is always 0 and is dropped.
        if (idx_q == LAST) begin
          idx_d   = '0;
          carry_d = 1'b0;
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      neg_zero_d = &sum_d;
      ovf_d      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      result_d   = ((NORMALIZE_ZERO != 0) && (&sum_d)) ? '0 : sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      neg_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      neg_zero_q <= neg_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ADD) || (state_q == WRAP);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.neg_zero  = neg_zero_q;

endmodule

// File: tb/tb_ones_comp_serial_alu.sv
// Bench for the serial ones'-complement ALU: raw (dut0) and zero-normalising (dut1)
// instances share one stimulus stream; expected results queue up at accept time.
module tb_ones_comp_serial_alu;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       ovf;
    logic       nz;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t sb_q[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  ones_comp_serial_alu_if #(.WIDTH(8)) bus0 ();
  ones_comp_serial_alu_if #(.WIDTH(8)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.sub       = bus0.sub;
  assign bus1.out_ready = bus0.out_ready;

  ones_comp_serial_alu #(.WIDTH(8), .DIGIT(4), .NORMALIZE_ZERO(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  ones_comp_serial_alu #(.WIDTH(8), .DIGIT(4), .NORMALIZE_ZERO(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: 9-bit sum, then end-around carry folded back.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    vec_t       v;
    logic [7:0] bp;
    logic [8:0] s;
    logic [7:0] raw;
    bp    = sub ? ~b : b;
    s     = {1'b0, a} + {1'b0, bp};
    raw   = s[7:0] + {7'd0, s[8]};
    v.a   = a;
    v.b   = b;
    v.sub = sub;
    v.res = raw;
    v.nz  = (raw == 8'hFF);
    v.ovf = (a[7] == bp[7]) && (raw[7] != a[7]);
    v.lat = s[8] ? 4 : 2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    while (!bus0.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_before_send", {31'd0, bus0.in_ready}, 32'd1);
    bus0.in_valid = 1'b1;
    bus0.a        = v.a;
    bus0.b        = v.b;
    bus0.sub      = v.sub;
    tick();
    sb_q.push_back(v);
    bus0.in_valid = 1'b0;
    bus0.a        = 8'($urandom);
    bus0.b        = 8'($urandom);
    bus0.sub      = 1'($urandom);
  endtask

  // Entered #1 after the accepting edge; counts edges until out_valid.
  task automatic receive();
    vec_t e;
    int   lat = 0;
    while (!bus0.out_valid && lat < 40) begin
      chk("busy_in_flight", {31'd0, bus0.busy}, 32'd1);
      tick();
      lat++;
    end
    if (!bus0.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got no out_valid after %0d cycles, expected one", lat);
      return;
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got a result, expected none");
      return;
    end
    e = sb_q.pop_front();
    chk("latency", lat, e.lat);
    chk("result", {24'd0, bus0.result}, {24'd0, e.res});
    chk("ovf", {31'd0, bus0.ovf}, {31'd0, e.ovf});
    chk("neg_zero", {31'd0, bus0.neg_zero}, {31'd0, e.nz});
    chk("norm_out_valid", {31'd0, bus1.out_valid}, 32'd1);
    chk("norm_result", {24'd0, bus1.result}, e.nz ? 32'd0 : {24'd0, e.res});
    chk("norm_neg_zero", {31'd0, bus1.neg_zero}, {31'd0, e.nz});
    chk("norm_ovf", {31'd0, bus1.ovf}, {31'd0, e.ovf});
  endtask

  task automatic handshake();
    tick();
    chk("out_valid_after_hs", {31'd0, bus0.out_valid}, 32'd0);
    chk("in_ready_after_hs", {31'd0, bus0.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //         a      b      sub   res    ovf   nz    lat
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 2};
    tbl[1] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0, 4};
    tbl[2] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b0, 1'b1, 2};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0, 2};
    tbl[4] = '{8'h80, 8'hFE, 1'b0, 8'h7F, 1'b1, 1'b0, 4};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2};
    tbl[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 2};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 8'hDD, 1'b0, 1'b0, 2};
    tbl[8] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1, 4};

    reset          = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.a         = 8'h00;
    bus0.b         = 8'h00;
    bus0.sub       = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
    chk("rst_result", {24'd0, bus0.result}, 32'd0);
    chk("rst_ovf", {31'd0, bus0.ovf}, 32'd0);
    chk("rst_neg_zero", {31'd0, bus0.neg_zero}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      send(tbl[i]);
      receive();
      handshake();
    end

    for (int i = 0; i < 16; i++) begin
      v = model(8'($urandom), 8'($urandom), 1'($urandom));
      send(v);
      receive();
      handshake();
    end

    // Backpressure: result holds while new operands wait outside.
    bus0.out_ready = 1'b0;
    send(tbl[0]);
    receive();
    bus0.in_valid = 1'b1;
    bus0.a        = 8'h11;
    bus0.b        = 8'h22;
    bus0.sub      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", {31'd0, bus0.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus0.in_ready}, 32'd0);
      chk("bp_result", {24'd0, bus0.result}, 32'h08);
      chk("bp_ovf", {31'd0, bus0.ovf}, 32'd0);
    end
    bus0.out_ready = 1'b1;
    handshake();
    tick();
    sb_q.push_back(model(8'h11, 8'h22, 1'b0));
    bus0.in_valid = 1'b0;
    receive();
    handshake();

    // Reset in the third in-flight cycle (WRAP) drops the operation.
    send(tbl[1]);
    tick();
    tick();
    chk("pre_reset_busy", {31'd0, bus0.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    chk("mid_rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("mid_rst_result", {24'd0, bus0.result}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, bus0.busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_result", {31'd0, bus0.out_valid}, 32'd0);
    end
    send(model(8'h01, 8'h01, 1'b0));
    receive();
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
